// File: rtl/adder_seq.sv
// adder_seq: multi-cycle adder/subtractor (ADD, SUB, ADC, SBC). Operands are latched
//   when an operation is accepted. The sum is then built CHUNK bits per clock, LSB chunk
//   first, and the carry passes between chunks through a register.
// Latency: N = WIDTH/CHUNK cycles from the accepting edge to the done pulse.
//   A new operation can start in the done cycle, so back-to-back operations take N+1 cycles.
// Backpressure: start is ignored while busy. Operands are not resampled during that time.
//   out_data, cy and zero (and ov) change only at completion.
//
// Ports:
//   clk, rst_n           rising-edge clock; asynchronous active-low reset
//   start                request; accepted only when busy==0
//   sub                  1: in_data1 - in_data2, 0: in_data1 + in_data2
//   use_cy               carry-in comes from the cy flag (ADC/SBC); otherwise carry-in = sub
//   in_data1, in_data2   operands, sampled at the accepting edge
//   busy                 operation in progress
//   done                 one-cycle pulse when the result and flags update
//   out_data, cy, zero   result, carry flag (SUB: 1 = no borrow), result==0
//   ov                   signed overflow flag; present only when OVERFLOW_FLAG_EN is defined
//
// Build option: define OVERFLOW_FLAG_EN to add the ov output and its logic.

module adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             use_cy,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic             cy,
`ifdef OVERFLOW_FLAG_EN
  output logic             zero,
  output logic             ov
`else
  output logic             zero
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;     // operand B, already inverted for subtraction
  logic             r_c;     // carry passed between chunks
  logic [WIDTH-1:0] r_res;   // partial result, filled one chunk at a time
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_cy;
  logic             r_zero;
`ifdef OVERFLOW_FLAG_EN
  logic             r_ov;
`endif

  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_cin;
  logic [WIDTH-1:0] w_b_eff;

  // Select the operand chunk for the current counter value. Every loop index is a
  // constant, so this builds a plain mux and needs no variable part-select.
  always_comb begin
    w_a_ch = '0;
    w_b_ch = '0;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_ch = r_a[i*CHUNK +: CHUNK];
        w_b_ch = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  // Add one chunk with one extra bit. The top bit of the sum is the carry into the next chunk.
  always_comb begin
    w_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_c};
  end

  // This is the partial result with the current chunk written in. On the last chunk it
  // is the full result, so out_data takes it from here at completion.
  always_comb begin
    w_res_next = r_res;
    for (int i = 0; i < N; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_res_next[i*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end
    end
  end

  assign w_last = (r_cnt == CNT_LAST);

  // Subtraction is A + ~B + 1. The "+1" is the carry-in, which is set to sub unless the
  // caller chains from the stored carry flag (ADC/SBC).
  assign w_b_eff = sub ? ~in_data2 : in_data2;
  assign w_cin   = use_cy ? r_cy : sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_cy    <= 1'b0;
      r_zero  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      r_ov    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= in_data1;
            r_b     <= w_b_eff;
            r_c     <= w_cin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res <= w_res_next;
          r_c   <= w_sum[CHUNK];
          if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_out   <= w_res_next;
            r_cy    <= w_sum[CHUNK];
            r_zero  <= (w_res_next == '0);
`ifdef OVERFLOW_FLAG_EN
            // Signed overflow: the operands have the same sign and the result has the
            // other sign. This is the same as carry into the MSB XOR carry out of it.
            r_ov    <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign out_data = r_out;
  assign cy       = r_cy;
  assign zero     = r_zero;
`ifdef OVERFLOW_FLAG_EN
  assign ov       = r_ov;
`endif

endmodule
